// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pattern mode encodings, colour-bar table and clog2 helper
package video_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // {R,G,B} channel-on mask per bar, left to right across the line
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// rtl/video_timing_counter.sv - h/v/frame counters with raw DE/HSA/VSA region decode
module video_timing_counter
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic          run_o,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          frame_lsb_o,
    output logic          h_last_o,
    output logic          de_o,
    output logic          hsa_o,
    output logic          vsa_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_S = H_ACTIVE + H_FP;
    localparam int H_SYNC_E = H_SYNC_S + H_SYNC;
    localparam int V_SYNC_S = V_ACTIVE + V_FP;
    localparam int V_SYNC_E = V_SYNC_S + V_SYNC;

    if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        HW < clog2(H_TOTAL) || VW < clog2(V_TOTAL)) begin : g_param_check
        $error("video_timing_counter: invalid timing geometry");
    end

    logic          en_q, en_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [7:0]    frame_q, frame_d;
    logic          run, h_last, v_last;

    // One idle cycle after Enable rises so the first running cycle sits at (0,0)
    assign run    = enable_i && en_q;
    assign h_last = (h_q == HW'(H_TOTAL - 1));
    assign v_last = (v_q == VW'(V_TOTAL - 1));

    always_comb begin
        en_d    = enable_i;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (!run) begin
            h_d     = '0;
            v_d     = '0;
            frame_d = '0;
        end else if (h_last) begin
            h_d = '0;
            if (v_last) begin
                v_d     = '0;
                frame_d = frame_q + 8'd1;
            end else begin
                v_d = v_q + 1'b1;
            end
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            en_q    <= en_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    assign run_o       = run;
    assign h_o         = h_q;
    assign v_o         = v_q;
    assign frame_lsb_o = frame_q[0];
    assign h_last_o    = h_last;
    assign de_o        = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hsa_o       = (h_q >= HW'(H_SYNC_S)) && (h_q < HW'(H_SYNC_E));
    assign vsa_o       = (v_q >= VW'(V_SYNC_S)) && (v_q < VW'(V_SYNC_E));

endmodule

// File: rtl/rgb_timing_pattern_gen.sv
// rtl/rgb_timing_pattern_gen.sv - parametrised VSA/HSA/DE timing source with test-pattern RGB
module rgb_timing_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 23,
    parameter int SYNC_POL    = 0,
    parameter int DATA_W      = 8,
    parameter int CHECK_SHIFT = 5,
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW         = clog2(H_TOTAL),
    localparam int VW         = clog2(V_TOTAL)
) (
    input  logic                  Sys_Clock,
    input  logic                  Reset_IN,
    input  logic                  Enable,
    input  logic [1:0]            Mode,
    input  logic [3*DATA_W-1:0]   Solid_RGB,
    output logic                  VSA,
    output logic                  HSA,
    output logic                  DE,
    output logic [DATA_W-1:0]     R,
    output logic [DATA_W-1:0]     G,
    output logic [DATA_W-1:0]     B,
    output logic [HW-1:0]         Pixel_Cnt,
    output logic [VW-1:0]         Line_Cnt,
    output logic                  Frame_Start
);

    localparam int   BAR_W     = H_ACTIVE / 8;
    localparam int   BW        = clog2(BAR_W);
    localparam logic SYNC_IDLE = (SYNC_POL == 0);

    logic          run, h_last, frame_lsb, de_raw, hsa_raw, vsa_raw;
    logic [HW-1:0] h;
    logic [VW-1:0] v;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_counter (
        .clk_i       (Sys_Clock),
        .rst_ni      (Reset_IN),
        .enable_i    (Enable),
        .run_o       (run),
        .h_o         (h),
        .v_o         (v),
        .frame_lsb_o (frame_lsb),
        .h_last_o    (h_last),
        .de_o        (de_raw),
        .hsa_o       (hsa_raw),
        .vsa_o       (vsa_raw)
    );

    logic                frame_first, chk;
    mode_e               mode_q, mode_d;
    logic [3*DATA_W-1:0] solid_q, solid_d, rgb, rgb_q, rgb_d;
    logic [2:0]          bar_idx_q, bar_idx_d, mask;
    logic [BW-1:0]       bar_pix_q, bar_pix_d;
    logic                de_q, de_d, hsa_q, hsa_d, vsa_q, vsa_d, fs_q, fs_d;
    logic [HW-1:0]       pix_q, pix_d;
    logic [VW-1:0]       line_q, line_d;

    assign frame_first = run && (h == '0) && (v == '0);

    // Live inputs drive the first pixel; the latched copy holds for the rest of the frame
    always_comb begin
        mode_d  = frame_first ? mode_e'(Mode) : mode_q;
        solid_d = frame_first ? Solid_RGB : solid_q;
    end

    // Bar index tracks h without a divider; saturation at 7 blacks out any remainder pixels
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_pix_d = bar_pix_q;
        if (!run || h_last) begin
            bar_idx_d = '0;
            bar_pix_d = '0;
        end else if (bar_pix_q == BW'(BAR_W - 1)) begin
            bar_pix_d = '0;
            if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_pix_d = bar_pix_q + 1'b1;
        end
    end

    always_comb begin
        mask = bar_mask(bar_idx_q);
        chk  = 1'(h >> CHECK_SHIFT) ^ 1'(v >> CHECK_SHIFT) ^ frame_lsb;
        rgb  = '0;
        if (de_raw) begin
            case (mode_d)
                MODE_SOLID: rgb = solid_d;
                MODE_BARS:  rgb = {{DATA_W{mask[2]}}, {DATA_W{mask[1]}}, {DATA_W{mask[0]}}};
                MODE_GRAD:  rgb = {3{DATA_W'(h)}};
                MODE_CHECK: rgb = {(3*DATA_W){chk}};
                default:    rgb = '0;
            endcase
        end
    end

    always_comb begin
        de_d   = run && de_raw;
        hsa_d  = run ? (hsa_raw ^ SYNC_IDLE) : SYNC_IDLE;
        vsa_d  = run ? (vsa_raw ^ SYNC_IDLE) : SYNC_IDLE;
        rgb_d  = run ? rgb : '0;
        pix_d  = run ? h : '0;
        line_d = run ? v : '0;
        fs_d   = frame_first;
    end

    always_ff @(posedge Sys_Clock or negedge Reset_IN) begin
        if (!Reset_IN) begin
            mode_q    <= MODE_SOLID;
            solid_q   <= '0;
            bar_idx_q <= '0;
            bar_pix_q <= '0;
            de_q      <= 1'b0;
            hsa_q     <= SYNC_IDLE;
            vsa_q     <= SYNC_IDLE;
            rgb_q     <= '0;
            pix_q     <= '0;
            line_q    <= '0;
            fs_q      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            bar_idx_q <= bar_idx_d;
            bar_pix_q <= bar_pix_d;
            de_q      <= de_d;
            hsa_q     <= hsa_d;
            vsa_q     <= vsa_d;
            rgb_q     <= rgb_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            fs_q      <= fs_d;
        end
    end

    assign DE          = de_q;
    assign HSA         = hsa_q;
    assign VSA         = vsa_q;
    assign R           = rgb_q[3*DATA_W-1:2*DATA_W];
    assign G           = rgb_q[2*DATA_W-1:DATA_W];
    assign B           = rgb_q[DATA_W-1:0];
    assign Pixel_Cnt   = pix_q;
    assign Line_Cnt    = line_q;
    assign Frame_Start = fs_q;

endmodule

// File: tb/tb_rgb_timing_pattern_gen.sv
// tb/tb_rgb_timing_pattern_gen.sv - randomized bench against a frame-position reference model
module tb_rgb_timing_pattern_gen;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int CS = 1;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [1:0]  mode;
    logic [23:0] solid;

    logic       vsa0, hsa0, de0, fs0, vsa1, hsa1, de1, fs1;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [4:0] pix0, pix1;
    logic [2:0] line0, line1;

    always #5 clk = ~clk;

    rgb_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .DATA_W(8), .CHECK_SHIFT(CS)
    ) dut0 (
        .Sys_Clock(clk), .Reset_IN(rst_n), .Enable(en), .Mode(mode), .Solid_RGB(solid),
        .VSA(vsa0), .HSA(hsa0), .DE(de0), .R(r0), .G(g0), .B(b0),
        .Pixel_Cnt(pix0), .Line_Cnt(line0), .Frame_Start(fs0)
    );

    rgb_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1), .DATA_W(8), .CHECK_SHIFT(CS)
    ) dut1 (
        .Sys_Clock(clk), .Reset_IN(rst_n), .Enable(en), .Mode(mode), .Solid_RGB(solid),
        .VSA(vsa1), .HSA(hsa1), .DE(de1), .R(r1), .G(g1), .B(b1),
        .Pixel_Cnt(pix1), .Line_Cnt(line1), .Frame_Start(fs1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the frame is just the count of running cycles
    int          run_cycles;
    bit          en_prev;
    int          lat_mode;
    logic [23:0] lat_solid;
    bit          e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_rgb;
    int          e_pix, e_line;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic set_idle();
        e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_rgb = '0; e_pix = 0; e_line = 0;
    endtask

    task automatic model_edge();
        int h, v, f, idx;
        bit c;
        if (!rst_n) begin
            set_idle();
            run_cycles = 0;
            en_prev = 0;
        end else begin
            if (en && en_prev) begin
                h = run_cycles % HT;
                v = (run_cycles / HT) % VT;
                f = (run_cycles / FT) % 2;
                if (h == 0 && v == 0) begin
                    lat_mode  = int'(mode);
                    lat_solid = solid;
                end
                e_de   = (h < HA) && (v < VA);
                e_hs   = (h >= HA + HFP) && (h < HA + HFP + HS);
                e_vs   = (v >= VA + VFP) && (v < VA + VFP + VS);
                e_fs   = (h == 0) && (v == 0);
                e_pix  = h;
                e_line = v;
                e_rgb  = '0;
                if (e_de) begin
                    case (lat_mode)
                        0: e_rgb = lat_solid;
                        1: begin
                            idx = h / (HA / 8);
                            if (idx > 7) idx = 7;
                            e_rgb = bars[idx];
                        end
                        2: e_rgb = {3{8'(h)}};
                        default: begin
                            c = (((h >> CS) ^ (v >> CS) ^ f) & 1) != 0;
                            e_rgb = c ? 24'hFFFFFF : 24'h000000;
                        end
                    endcase
                end
                run_cycles++;
            end else begin
                set_idle();
                run_cycles = 0;
            end
            en_prev = en;
        end
    endtask

    task automatic compare_all();
        check_eq("de",    32'(de0),  32'(e_de));
        check_eq("hsa",   32'(hsa0), 32'(!e_hs));
        check_eq("vsa",   32'(vsa0), 32'(!e_vs));
        check_eq("rgb",   32'({r0, g0, b0}), 32'(e_rgb));
        check_eq("pix",   32'(pix0), 32'(e_pix));
        check_eq("line",  32'(line0), 32'(e_line));
        check_eq("fs",    32'(fs0),  32'(e_fs));
        check_eq("hsa_p1", 32'(hsa1), 32'(e_hs));
        check_eq("vsa_p1", 32'(vsa1), 32'(e_vs));
        check_eq("de_p1",  32'(de1),  32'(e_de));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic step_until_pos(input int target);
        int n;
        n = 0;
        while ((run_cycles % FT) != target && n < 2 * FT) begin
            step();
            n++;
        end
        check_eq("wait_pos", 32'(run_cycles % FT), 32'(target));
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        set_idle();
        run_cycles = 0;
        en_prev = 0;
        compare_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int nfs, nde, first_fs, lat, r;
        bit seen;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; solid = 24'h12A5C3;
        run_cycles = 0; en_prev = 0; lat_mode = 0; lat_solid = '0;
        set_idle();
        repeat (3) step();

        rst_n = 1'b1; en = 1'b1;
        nfs = 0; nde = 0; first_fs = -1;
        for (int i = 1; i <= 2 * FT + 1; i++) begin
            step();
            if (fs0) begin
                nfs++;
                if (first_fs < 0) first_fs = i;
            end
            if (de0) nde++;
        end
        check_eq("fs_first", 32'(first_fs), 32'd2);
        check_eq("fs_count", 32'(nfs), 32'd2);
        check_eq("de_count", 32'(nde), 32'(2 * HA * VA));

        mode = 2'd1;
        repeat (2 * FT) step();
        mode = 2'd3;
        repeat (2 * FT) step();

        mode = 2'd0; solid = 24'($urandom);
        step_until_pos(1);
        step_until_pos(2 * HT + 1);
        mode = 2'd2;
        repeat (2 * FT) step();

        step_until_pos(HT + 6);
        en = 1'b0;
        step();
        check_eq("drop_pix", 32'(pix0), 32'd0);
        repeat (3) step();
        en = 1'b1;
        lat = 0; seen = 0;
        while (lat < 8 && !seen) begin
            step();
            lat++;
            seen = fs0;
        end
        check_eq("restart_fs_lat", 32'(lat), 32'd2);

        repeat (40) step();
        reset_pulse();
        repeat (FT) step();

        for (int i = 0; i < 3000; i++) begin
            step();
            r = int'($urandom_range(0, 999));
            if (r < 20)       mode  = 2'($urandom_range(0, 3));
            else if (r < 40)  solid = 24'($urandom);
            else if (r < 43)  en    = 1'b0;
            else if (r < 44)  reset_pulse();
            else if (!en && r < 300) en = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_timing_pattern_gen.md
Name: rgb_timing_pattern_gen

Overview:
- Parametrised successor to the fixed RGB timing source and DDT pattern source.
- Generates the VSA/HSA/DE video timing for any panel geometry and sync polarity, plus a selectable test pattern on R/G/B.
- Sits in the Sys_Clock domain. It feeds M_SRAM as the RGB timing source, or drives the DDT inputs directly for self-test.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, HSA width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, VSA width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 0, sync polarity: 0 = VSA/HSA active-low, 1 = active-high
- DATA_W, 8, bits per colour channel
- CHECK_SHIFT, 5, checker cell size is 2^CHECK_SHIFT pixels/lines

Ports:
- Sys_Clock  in  1  system pixel clock
- Reset_IN  in  1  asynchronous active-low reset
- Enable  in  1  run timing; low = idle
- Mode  in  2  pattern select: 0 solid, 1 colour bars, 2 gradient, 3 checker
- Solid_RGB  in  3*DATA_W  colour for mode 0, packed {R,G,B}
- VSA  out  1  vertical sync, polarity per SYNC_POL
- HSA  out  1  horizontal sync, polarity per SYNC_POL
- DE  out  1  data enable, active-high
- R, G, B  out  DATA_W each  pixel data
- Pixel_Cnt  out  clog2(H_TOTAL)  current horizontal position
- Line_Cnt  out  clog2(V_TOTAL)  current vertical position
- Frame_Start  out  1  one-cycle pulse, aligned with first pixel of a frame

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; BAR_W = H_ACTIVE/8 (integer).
- Reset (Reset_IN low, async) values:
  - h = v = 0, frame counter = 0
  - DE = 0, R = G = B = 0, Frame_Start = 0
  - VSA/HSA at inactive level (high if SYNC_POL = 0)
  - latched mode = 0
- Counters:
  - h increments every clock while Enable; wraps at H_TOTAL-1 to 0.
  - v increments on h wrap; wraps at V_TOTAL-1 to 0.
  - Frame counter increments on v wrap (8 bits, wraps at 255).
- Region order per line: active [0, H_ACTIVE), FP, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), BP. The same order applies per frame on v.
- Outputs:
  - All outputs are registered, with one clock of latency from (h, v).
  - DE, HSA, VSA, R/G/B, Pixel_Cnt, Line_Cnt and Frame_Start are mutually aligned.
- Signal definitions:
  - DE = (h < H_ACTIVE) && (v < V_ACTIVE).
  - HSA is asserted whenever h is in the sync region, on every line including vertical blanking.
  - VSA is asserted for every clock of the lines with v in the vertical sync region.
  - Frame_Start = 1 exactly when h = 0 and v = 0 while Enable is high.
- Mode and Solid_RGB:
  - Both are sampled only at h = 0, v = 0.
  - A mid-frame change takes effect at the next frame; no partial-frame pattern change.
- Patterns (applied when DE = 1; R = G = B = 0 whenever DE = 0):
  - Mode 0: {R,G,B} = latched Solid_RGB.
  - Mode 1: 8 bars in the order white, yellow, cyan, green, magenta, red, blue, black; channels are all-ones or 0. The bar index comes from a per-line bar counter advancing every BAR_W pixels and saturating at 7, so any remainder pixels are black. No divider.
  - Mode 2: R = G = B = h[DATA_W-1:0], wrapping.
  - Mode 3: white if h[CHECK_SHIFT] ^ v[CHECK_SHIFT] ^ frame[0] else black; the pattern inverts every frame.
- Enable:
  - Enable low: counters clear to 0 synchronously at the next clock and outputs go to reset values.
  - Enable rising: the first clock after rising is h = 0, v = 0, and Frame_Start fires one cycle later.
  - Enable dropping mid-frame aborts the frame cleanly: no truncated sync pulse is extended.
- Reset mid-frame: immediate async return to reset values. Restart behaves as Enable rising.
- Elaboration checks: H_ACTIVE ≥ 8, and every porch/sync parameter ≥ 1.

Decomposition:
- Shared package (video_pkg):
  - Mode encodings MODE_SOLID/BARS/GRAD/CHECK
  - colour-bar constant table
  - clog2 function
- One sub-module, video_timing_counter: h/v/frame counters plus region decode (DE, HSA, VSA raw).
- The pattern mux and output registers stay in the top.

Test Plan:
Use H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24), V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8), SYNC_POL=0.
1. Reset release with Enable=1 -> Frame_Start pulses every 192 clocks. DE is high for 16 consecutive clocks per line, on lines 0-3 only, i.e. 64 clocks per frame.
2. HSA/VSA timing -> HSA is low for 3 clocks starting 18 clocks after the rising edge of DE on each line. VSA is low for 48 clocks starting at line 5. With SYNC_POL=1 both signals invert.
3. Mode=1, BAR_W=2 -> per line, pixels 0-1 are FFFFFF, 2-3 FFFF00, 4-5 00FFFF, …, and 14-15 000000.
4. Mode=3, CHECK_SHIFT=1 -> pixel (2,0) is white in frame 0 and black in frame 1.
5. Mode switched from 0 to 2 at line 2 -> the current frame remains solid Solid_RGB. The next frame outputs R = G = B = 0,1,…,15 per line.
6. Enable dropped at h=5, v=1, or Reset_IN pulsed low -> all outputs are at reset values on the next clock (asynchronously for reset). On restart, Frame_Start pulses 2 clocks after Enable rises.
